// File: rtl/uart_console_pkg.sv
// uart_console_pkg
// Shared constants for the console UART receive FIFO:
//   LINE_CHAR_DEFAULT - byte that terminates a text line (LF)
//   MODE_BACKPRESSURE / MODE_DROP - values for the DROP_WHEN_FULL parameter
//   occ_width()       - width of the occupancy counters (must hold 0..DEPTH)
package uart_console_pkg;

    localparam logic [7:0] LINE_CHAR_DEFAULT = 8'h0A;

    localparam bit MODE_BACKPRESSURE = 1'b0;
    localparam bit MODE_DROP         = 1'b1;

    // Occupancy runs 0..2**depth_log2 inclusive, hence one extra bit.
    function automatic int occ_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp
// 2**ADDR_W x 8 storage with one synchronous write port and one
// asynchronous read port (feeds a first-word fall-through head).
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data, mem[raddr]
module fifo_mem_dp #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Stored bytes are not cleared on reset; the head is only meaningful
    // while the FIFO is non-empty.
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_console_fifo.sv
// uart_console_fifo
// Byte FIFO behind the console UART receiver. Buffers characters for the
// host, counts complete lines and flags lost bytes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tready - upstream byte stream from the uart
//   m_tdata/m_tvalid/m_tready - first-word fall-through head of the FIFO
//   level           - current occupancy, 0..DEPTH
//   line_count      - number of LINE_CHAR bytes currently stored
//   line_ready      - at least one complete line stored
//   overflow        - sticky lost-byte flag
//   clear_overflow  - clears overflow (a simultaneous new loss wins)
module uart_console_fifo
    import uart_console_pkg::*;
#(
    parameter int         DEPTH_LOG2     = 4,
    parameter bit         DROP_WHEN_FULL = MODE_BACKPRESSURE,
    parameter logic [7:0] LINE_CHAR      = LINE_CHAR_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         s_tdata,
    input  logic                               s_tvalid,
    output logic                               s_tready,
    output logic [7:0]                         m_tdata,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [occ_width(DEPTH_LOG2)-1:0]   level,
    output logic [occ_width(DEPTH_LOG2)-1:0]   line_count,
    output logic                               line_ready,
    output logic                               overflow,
    input  logic                               clear_overflow
);

    localparam int                 OCC_W      = occ_width(DEPTH_LOG2);
    localparam int                 DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [OCC_W-1:0]   LEVEL_FULL = OCC_W'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [OCC_W-1:0]      level_reg;
    logic [OCC_W-1:0]      level_next;
    logic [OCC_W-1:0]      line_count_reg;
    logic [OCC_W-1:0]      line_count_next;
    logic                  overflow_reg;
    logic                  stall_reg;

    logic full;
    logic push;
    logic pop;
    logic line_in;
    logic line_out;
    logic stall_now;
    logic ovf_set;

    // Full is judged on the registered level only: a pop in the same cycle
    // does not free a slot for the incoming byte.
    assign full      = (level_reg == LEVEL_FULL);
    assign m_tvalid  = (level_reg != '0);
    assign push      = s_tvalid && !full;
    assign pop       = m_tvalid && m_tready;
    assign line_in   = push && (s_tdata == LINE_CHAR);
    assign line_out  = pop && (m_tdata == LINE_CHAR);
    assign stall_now = s_tvalid && full;

    assign s_tready = (DROP_WHEN_FULL == MODE_DROP) ? 1'b1 : !full;

    // Drop mode loses the byte immediately. In back-pressure mode the uart
    // has a single holding register, so a second consecutive stalled cycle
    // means a following byte has been overwritten upstream.
    assign ovf_set = stall_now && ((DROP_WHEN_FULL == MODE_DROP) || stall_reg);

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + 1'b1;
        end else if (pop && !push) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_comb begin
        line_count_next = line_count_reg;
        if (line_in && !line_out) begin
            line_count_next = line_count_reg + 1'b1;
        end else if (line_out && !line_in) begin
            line_count_next = line_count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            line_count_reg <= '0;
            overflow_reg   <= 1'b0;
            stall_reg      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg      <= level_next;
            line_count_reg <= line_count_next;
            stall_reg      <= stall_now;
            overflow_reg   <= ovf_set || (overflow_reg && !clear_overflow);
        end
    end

    fifo_mem_dp #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (s_tdata),
        .raddr (rd_ptr_reg),
        .rdata (m_tdata)
    );

    assign level      = level_reg;
    assign line_count = line_count_reg;
    assign line_ready = (line_count_reg != '0);
    assign overflow   = overflow_reg;

endmodule
